io1out_pad: RTL and testbench

Output-direction 1-bit I/O pad tile: the transmit end of the pad interface whose input-direction tile fans `top_pin` onto fabric tracks. It takes four fabric tracks and a track select, with optional inversion and optional output registering, and drives one chip pin plus its output enable. After every configuration write, a blanking state machine holds the output enable low for a programmable settle period, so reconfiguration never glitches the pad.

---
 rtl/io_pad_pkg.sv | 25 ++
 rtl/io_pad_blank_fsm.sv | 68 ++++++
 rtl/io1out_pad.sv | 82 ++++++++
 tb/tb_io1out_pad.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/io_pad_pkg.sv
// Shared definitions for the 1-bit I/O pad tiles: config word layout and
// the output-blanking state encoding.
package io_pad_pkg;

   localparam int CFG_W     = 8;

   localparam int SEL_LO    = 0;
   localparam int SEL_W     = 2;
   localparam int INV_BIT   = 2;
   localparam int REG_BIT   = 3;
   localparam int DRV_BIT   = 4;
   localparam int SETTLE_LO = 5;
   localparam int SETTLE_W  = 3;

   // Bit of the state code that is set only in DRIVE, so the output enable
   // comes straight off a flop.
   localparam int OE_STATE_BIT = 1;

   typedef enum logic [1:0] {
      OFF   = 2'b00,
      BLANK = 2'b01,
      DRIVE = 2'b10
   } pad_state_t;

endpackage

// File: rtl/io_pad_blank_fsm.sv
// Output-enable blanking controller: every config write forces the pad off,
// and a driving config only re-enables it after the programmed settle count.
module io_pad_blank_fsm
   import io_pad_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                config_en,
   input  logic                drive_en_in,
   input  logic [SETTLE_W-1:0] settle_in,
   output logic                oe
);

   localparam logic [SETTLE_W-1:0] CNT_ZERO = {SETTLE_W{1'b0}};
   localparam logic [SETTLE_W-1:0] CNT_ONE  = {{(SETTLE_W-1){1'b0}}, 1'b1};

   pad_state_t          state;
   pad_state_t          state_nxt;
   logic [SETTLE_W-1:0] cnt;
   logic [SETTLE_W-1:0] cnt_nxt;

   // State and settle counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= OFF;
         cnt   <= CNT_ZERO;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state: any write re-arms blanking; the counter only decrements from nonzero.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (config_en) begin
         if (drive_en_in) begin
            state_nxt = BLANK;
            cnt_nxt   = settle_in;
         end else begin
            state_nxt = OFF;
            cnt_nxt   = cnt;
         end
      end else begin
         case (state)
            BLANK: begin
               if (cnt == CNT_ZERO) begin
                  state_nxt = DRIVE;
                  cnt_nxt   = cnt;
               end else begin
                  state_nxt = BLANK;
                  cnt_nxt   = cnt - CNT_ONE;
               end
            end
            DRIVE:   state_nxt = DRIVE;
            OFF:     state_nxt = OFF;
            default: state_nxt = OFF;
         endcase
      end
   end

   // Output enable decoded from a single state flop bit.
   always_comb begin
      oe = state[OE_STATE_BIT];
   end

endmodule

// File: rtl/io1out_pad.sv
// Output-direction 1-bit pad tile: selects one of four fabric tracks, with
// optional inversion and registering, and drives the chip pin and its enable.
module io1out_pad
   import io_pad_pkg::*;
#(
   parameter int CFG_W = 32'd8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pin_0,
   input  logic             pin_1,
   input  logic             pin_2,
   input  logic             pin_3,
   input  logic             config_en,
   input  logic [CFG_W-1:0] config_data,
   output logic [CFG_W-1:0] config_out,
   output logic [0:0]       top_pin,
   output logic [0:0]       top_oe
);

   logic [CFG_W-1:0] cfg;
   logic [3:0]       pins;
   logic [SEL_W-1:0] sel;
   logic             invert;
   logic             registered;
   logic             d;
   logic             q;
   logic             raw;
   logic             oe;

   assign pins = {pin_3, pin_2, pin_1, pin_0};

   // Configuration register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cfg <= {CFG_W{1'b0}};
      end else if (config_en) begin
         cfg <= config_data;
      end else begin
         cfg <= cfg;
      end
   end

   // Output data register keeps sampling while blanked so it is never stale when driving starts.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= 1'b0;
      end else begin
         q <= d;
      end
   end

   // Track select, inversion and registered/bypass choice.
   always_comb begin
      sel        = cfg[SEL_LO +: SEL_W];
      invert     = cfg[INV_BIT];
      registered = cfg[REG_BIT];
      d          = pins[sel] ^ invert;
      if (registered) begin
         raw = q;
      end else begin
         raw = d;
      end
   end

   io_pad_blank_fsm u_blank_fsm (
      .clk         (clk),
      .rst         (rst),
      .config_en   (config_en),
      .drive_en_in (config_data[DRV_BIT]),
      .settle_in   (config_data[SETTLE_LO +: SETTLE_W]),
      .oe          (oe)
   );

   // Pad outputs; the pin is held low whenever it is not driven.
   always_comb begin
      config_out = cfg;
      top_oe[0]  = oe;
      top_pin[0] = raw & oe;
   end

endmodule

// File: tb/tb_io1out_pad.sv
// Scoreboard bench for io1out_pad: a cycle-level reference model pushes
// expected outputs, a negedge monitor pops and compares.
module tb_io1out_pad;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       config_en = 1'b0;
   logic [7:0] config_data = 8'h00;
   logic [3:0] pins = 4'h0;
   logic [7:0] config_out;
   logic [0:0] top_pin;
   logic [0:0] top_oe;

   always #5 clk = ~clk;

   io1out_pad #(.CFG_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .pin_0       (pins[0]),
      .pin_1       (pins[1]),
      .pin_2       (pins[2]),
      .pin_3       (pins[3]),
      .config_en   (config_en),
      .config_data (config_data),
      .config_out  (config_out),
      .top_pin     (top_pin),
      .top_oe      (top_oe)
   );

   typedef struct {
      logic       pin;
      logic       oe;
      logic [7:0] cfg;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc_n  = 0;

   // Reference model: blanking expressed as "cycles since last write > settle".
   logic [7:0] m_cfg   = 8'h00;
   logic       m_q     = 1'b0;
   bit         m_armed = 1'b0;
   int         m_since = 0;
   int         m_settle = 0;

   task automatic cyc(input logic r, input logic ce, input logic [7:0] cd, input logic [3:0] p_next);
      exp_t e;
      logic raw;
      rst         = r;
      config_en   = ce;
      config_data = cd;
      @(posedge clk);
      if (r) begin
         m_cfg   = 8'h00;
         m_q     = 1'b0;
         m_armed = 1'b0;
         m_since = 0;
      end else begin
         m_q = pins[m_cfg[1:0]] ^ m_cfg[2];
         if (ce) begin
            m_cfg    = cd;
            m_armed  = cd[4];
            m_settle = int'(cd[7:5]);
            m_since  = 0;
         end else begin
            m_since = m_since + 1;
         end
      end
      #1;
      pins      = p_next;
      rst       = 1'b0;
      config_en = 1'b0;
      cyc_n     = cyc_n + 1;
      e.oe  = m_armed && (m_since > m_settle);
      raw   = m_cfg[3] ? m_q : (pins[m_cfg[1:0]] ^ m_cfg[2]);
      e.pin = raw & e.oe;
      e.cfg = m_cfg;
      e.cyc = cyc_n;
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 4'($urandom));
   endtask

   // Monitor: compare every presented output against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks = checks + 3;
         if (top_oe[0] !== e.oe) begin
            errors = errors + 1;
            $display("FAIL top_oe cycle %0d actual %b required %b", e.cyc, top_oe[0], e.oe);
         end
         if (top_pin[0] !== e.pin) begin
            errors = errors + 1;
            $display("FAIL top_pin cycle %0d actual %b required %b", e.cyc, top_pin[0], e.pin);
         end
         if (config_out !== e.cfg) begin
            errors = errors + 1;
            $display("FAIL config_out cycle %0d actual %02h required %02h", e.cyc, config_out, e.cfg);
         end
      end
   end

   initial begin
      // Reset with all tracks high, then a long quiet period.
      pins = 4'hF;
      cyc(1'b1, 1'b0, 8'h00, 4'hF);
      cyc(1'b1, 1'b0, 8'h00, 4'hF);
      idle(20);

      // Unregistered, track 2, settle 3.
      cyc(1'b0, 1'b1, 8'h72, 4'($urandom));
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 8'h00, {1'b0, i[0], 2'b00} ^ 4'($urandom & 32'hB));

      // Registered, inverted, track 1, settle 0.
      cyc(1'b0, 1'b1, 8'h1D, 4'($urandom));
      idle(8);

      // Re-write during blanking restarts the count; a disabling write drops the pad at once.
      cyc(1'b0, 1'b1, 8'hF0, 4'($urandom));
      idle(3);
      cyc(1'b0, 1'b1, 8'hF0, 4'($urandom));
      idle(10);
      cyc(1'b0, 1'b1, 8'h00, 4'hF);
      idle(3);

      // Reset wins over a simultaneous write; reset during blanking keeps the pad off.
      cyc(1'b0, 1'b1, 8'h14, 4'($urandom));
      idle(3);
      cyc(1'b1, 1'b1, 8'h10, 4'($urandom));
      idle(4);
      cyc(1'b0, 1'b1, 8'hF0, 4'($urandom));
      idle(2);
      cyc(1'b1, 1'b0, 8'h00, 4'($urandom));
      idle(12);

      // All sel/invert/registered combinations while driving.
      for (int c = 0; c < 16; c++) begin
         cyc(1'b0, 1'b1, 8'h10 | 8'(c), 4'($urandom));
         idle(6);
      end

      // Fully random configs and gaps, including back-to-back writes.
      for (int k = 0; k < 40; k++) begin
         cyc(1'b0, 1'b1, 8'($urandom), 4'($urandom));
         idle(int'($urandom_range(0, 10)));
      end

      @(negedge clk);
      #1;
      checks = checks + 1;
      if (sb.size() != 0) begin
         errors = errors + 1;
         $display("FAIL scoreboard_drain actual %0d pending required 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
